// File: rtl/gpio_port_if.sv
// ============================================================================
// Module      : data_bus (interface)
// Description : Simple request/grant register bus with one-cycle read return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_bus;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/gpio_port.sv
// ============================================================================
// Module      : gpio_port
// Description : Memory-mapped GPIO port with input synchroniser and optional
//               edge interrupts (enabled by macro GPIO_PORT_IRQ_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_port #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    data_bus.slave           dbus,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] oe,
    input  logic [WIDTH-1:0] din,
    output logic             irq
);

    localparam logic [11:0] c_ODR = 12'h000;
    localparam logic [11:0] c_IDR = 12'h004;
    localparam logic [11:0] c_DIR = 12'h008;
    localparam logic [11:0] c_SET = 12'h00C;
    localparam logic [11:0] c_CLR = 12'h010;
    localparam logic [11:0] c_IRE = 12'h014;
    localparam logic [11:0] c_IFE = 12'h018;
    localparam logic [11:0] c_ISR = 12'h01C;

    logic [WIDTH-1:0] r_odr;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic             r_rvalid;
    logic [31:0]      r_rdata;

    logic             w_wr;
    logic             w_rd;
    logic [11:0]      w_off;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_idr;
    logic [WIDTH-1:0] w_ire;
    logic [WIDTH-1:0] w_ife;
    logic [WIDTH-1:0] w_isr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_wr     = dbus.req & dbus.we;
    assign w_rd     = dbus.req & ~dbus.we;
    assign w_off    = dbus.addr[11:0];
    assign w_wdata  = dbus.wdata[WIDTH-1:0];
    assign w_idr    = r_sync[SYNC_STAGES-1];
    assign w_unused = ^{dbus.addr[31:12], dbus.wdata};

    assign dbus.gnt    = dbus.req;
    assign dbus.rvalid = r_rvalid;
    assign dbus.rdata  = r_rdata;
    assign dout        = r_odr;
    assign oe          = r_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_odr <= '0;
            r_dir <= '0;
        end else if (w_wr) begin
            case (w_off)
                c_ODR:   r_odr <= w_wdata;
                c_SET:   r_odr <= r_odr | w_wdata;
                c_CLR:   r_odr <= r_odr & ~w_wdata;
                c_DIR:   r_dir <= w_wdata;
                default: ;
            endcase
        end
    end

`ifdef GPIO_PORT_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_ire;
    logic [WIDTH-1:0] r_ife;
    logic [WIDTH-1:0] r_isr;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_w1c;

    // Events use the enables as they stand when the edge is seen, so a later
    // enable write never picks up an old edge.
    assign w_set = ((w_idr & ~r_prev) & r_ire) | ((~w_idr & r_prev) & r_ife);
    assign w_w1c = (w_wr && (w_off == c_ISR)) ? w_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            r_ire  <= '0;
            r_ife  <= '0;
            r_isr  <= '0;
        end else begin
            r_prev <= w_idr;
            r_isr  <= (r_isr & ~w_w1c) | w_set;
            if (w_wr && (w_off == c_IRE)) r_ire <= w_wdata;
            if (w_wr && (w_off == c_IFE)) r_ife <= w_wdata;
        end
    end

    assign w_ire = r_ire;
    assign w_ife = r_ife;
    assign w_isr = r_isr;
    assign irq   = |r_isr;
`else
    assign w_ire = '0;
    assign w_ife = '0;
    assign w_isr = '0;
    assign irq   = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_ODR:   w_rdata[WIDTH-1:0] = r_odr;
            c_IDR:   w_rdata[WIDTH-1:0] = w_idr;
            c_DIR:   w_rdata[WIDTH-1:0] = r_dir;
            c_IRE:   w_rdata[WIDTH-1:0] = w_ire;
            c_IFE:   w_rdata[WIDTH-1:0] = w_ife;
            c_ISR:   w_rdata[WIDTH-1:0] = w_isr;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= dbus.req;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpio_port.sv
// ============================================================================
// Module      : tb_gpio_port
// Description : Randomised and directed bench for gpio_port against a
//               delay-line / register-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_port;

    localparam int W  = 8;
    localparam int SS = 2;
`ifdef GPIO_PORT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    localparam logic [31:0] A_ODR = 32'h000;
    localparam logic [31:0] A_IDR = 32'h004;
    localparam logic [31:0] A_DIR = 32'h008;
    localparam logic [31:0] A_SET = 32'h00C;
    localparam logic [31:0] A_CLR = 32'h010;
    localparam logic [31:0] A_IRE = 32'h014;
    localparam logic [31:0] A_IFE = 32'h018;
    localparam logic [31:0] A_ISR = 32'h01C;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dout;
    logic [W-1:0] oe;
    logic [W-1:0] din;
    logic         irq;

    data_bus bus ();

    gpio_port #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk  (clk),
        .rst  (rst),
        .dbus (bus),
        .dout (dout),
        .oe   (oe),
        .din  (din),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [W-1:0] m_odr, m_dir, m_ire, m_ife, m_isr;
    logic         m_rvalid;
    logic [31:0]  m_rdata;
    logic [W-1:0] hist [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_odr = '0; m_dir = '0; m_ire = '0; m_ife = '0; m_isr = '0;
        m_rvalid = 1'b0; m_rdata = '0;
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back('0);
    endtask

    task automatic compare_all();
        check("dout",   {24'b0, dout}, {24'b0, m_odr});
        check("oe",     {24'b0, oe},   {24'b0, m_dir});
        check("irq",    {31'b0, irq},  {31'b0, |m_isr});
        check("rvalid", {31'b0, bus.rvalid}, {31'b0, m_rvalid});
        check("rdata",  bus.rdata, m_rdata);
    endtask

    // One bus cycle: drive before the edge, advance the model at the edge,
    // then compare every output just after it.
    task automatic step(input bit rq, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [W-1:0] pins);
        logic [W-1:0] idr_cur, idr_prv, ev, w1c;
        @(negedge clk);
        bus.req = rq; bus.we = w; bus.addr = a; bus.wdata = d; din = pins;
        #1;
        check("gnt", {31'b0, bus.gnt}, {31'b0, rq});
        @(posedge clk);
        idr_cur = hist[SS-1];
        idr_prv = hist[SS];
        ev  = IRQ_ON ? ((idr_cur & ~idr_prv & m_ire) | (~idr_cur & idr_prv & m_ife)) : '0;
        w1c = '0;
        if (rq && !w) begin
            case (a[11:0])
                12'h000: m_rdata = {24'b0, m_odr};
                12'h004: m_rdata = {24'b0, idr_cur};
                12'h008: m_rdata = {24'b0, m_dir};
                12'h014: m_rdata = {24'b0, m_ire};
                12'h018: m_rdata = {24'b0, m_ife};
                12'h01C: m_rdata = {24'b0, m_isr};
                default: m_rdata = 32'h0;
            endcase
        end
        m_rvalid = rq;
        if (rq && w) begin
            case (a[11:0])
                12'h000: m_odr = d[W-1:0];
                12'h008: m_dir = d[W-1:0];
                12'h00C: m_odr = m_odr | d[W-1:0];
                12'h010: m_odr = m_odr & ~d[W-1:0];
                12'h014: if (IRQ_ON) m_ire = d[W-1:0];
                12'h018: if (IRQ_ON) m_ife = d[W-1:0];
                12'h01C: if (IRQ_ON) w1c = d[W-1:0];
                default: ;
            endcase
        end
        m_isr = (m_isr & ~w1c) | ev;
        hist.push_front(pins);
        void'(hist.pop_back());
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic [W-1:0] pins);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, pins);
    endtask

    logic [11:0]  offs [10] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                               12'h014, 12'h018, 12'h01C, 12'h040, 12'hFFC};
    logic [W-1:0] rpins;
    logic [31:0]  rnd;

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #3 rst = 1'b0;

        // ODR / SET / CLR sequence
        step(1, 1, A_ODR, 32'h0000_00F0, 8'h00);
        check("odr_f0", {24'b0, dout}, 32'hF0);
        check("rvalid_wr", {31'b0, bus.rvalid}, 32'h1);
        step(1, 1, A_SET, 32'h0F, 8'h00);
        check("set_ff", {24'b0, dout}, 32'hFF);
        step(1, 1, A_CLR, 32'h30, 8'h00);
        check("clr_cf", {24'b0, dout}, 32'hCF);
        idle(1, 8'h00);
        check("rvalid_idle", {31'b0, bus.rvalid}, 32'h0);

        // width truncation, unmapped and write-only reads
        step(1, 1, A_ODR, 32'hFFFF_FFFF, 8'h00);
        step(1, 0, A_ODR, 32'h0, 8'h00);
        check("odr_trunc", bus.rdata, 32'h0000_00FF);
        step(1, 0, 32'h040, 32'h0, 8'h00);
        check("unmapped_rd", bus.rdata, 32'h0);
        step(1, 0, A_SET, 32'h0, 8'h00);
        check("set_rd", bus.rdata, 32'h0);
        step(1, 1, A_IDR, 32'hFF, 8'h00);
        step(1, 0, A_IDR, 32'h0, 8'h00);
        check("idr_ro", bus.rdata, 32'h0);

        // synchroniser latency: E0 is the first edge that sees 0x05
        idle(3, 8'h00);
        step(1, 0, A_IDR, 32'h0, 8'h05);
        check("idr_e0", bus.rdata, 32'h0);
        step(1, 0, A_IDR, 32'h0, 8'h05);
        check("idr_e1", bus.rdata, 32'h0);
        step(1, 0, A_IDR, 32'h0, 8'h05);
        check("idr_e2", bus.rdata, 32'h05);
        idle(4, 8'h00);

        // edge interrupts: pin0 rising, pin1 falling
        step(1, 1, A_IRE, 32'h1, 8'h00);
        step(1, 1, A_IFE, 32'h2, 8'h00);
        idle(4, 8'h01);
        step(1, 0, A_ISR, 32'h0, 8'h01);
        check("isr_rise0", bus.rdata, IRQ_ON ? 32'h1 : 32'h0);
        idle(4, 8'h03);
        idle(4, 8'h02);
        step(1, 0, A_ISR, 32'h0, 8'h02);
        check("isr_nofall0", bus.rdata, IRQ_ON ? 32'h1 : 32'h0);
        idle(4, 8'h00);
        step(1, 0, A_ISR, 32'h0, 8'h00);
        check("isr_fall1", bus.rdata, IRQ_ON ? 32'h3 : 32'h0);
        check("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});

        step(1, 1, A_ISR, 32'h3, 8'h00);
        check("irq_w1c", {31'b0, irq}, 32'h0);

        // W1C coinciding with a new pin-0 rise: set wins
        step(0, 0, 32'h0, 32'h0, 8'h01);
        step(0, 0, 32'h0, 32'h0, 8'h01);
        step(1, 1, A_ISR, 32'h1, 8'h01);
        check("irq_setwins", {31'b0, irq}, {31'b0, IRQ_ON});
        step(1, 0, A_ISR, 32'h0, 8'h01);
        check("isr_setwins", bus.rdata, IRQ_ON ? 32'h1 : 32'h0);
        step(1, 1, A_ISR, 32'h1, 8'h01);
        check("irq_clr", {31'b0, irq}, 32'h0);
        idle(3, 8'h00);

        // randomised traffic
        rpins = '0;
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 3) == 0) rpins = rnd[W-1:0];
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 {($urandom_range(0, 3) == 0) ? 20'h00001 : 20'h00000,
                  offs[$urandom_range(0, 9)]},
                 $urandom(), rpins);
        end

        // reset in the middle of a DIR write
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = A_DIR; bus.wdata = 32'hFF;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_oe", {24'b0, oe}, 32'h0);
        check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        compare_all();
        bus.req = 1'b0;
        #2 rst = 1'b0;
        idle(1, 8'h00);
        check("rst_rvalid_after", {31'b0, bus.rvalid}, 32'h0);
        step(1, 0, A_DIR, 32'h0, 8'h00);
        check("rst_dir", bus.rdata, 32'h0);
        step(1, 0, A_ODR, 32'h0, 8'h00);
        check("rst_odr", bus.rdata, 32'h0);
        step(1, 0, A_ISR, 32'h0, 8'h00);
        check("rst_isr", bus.rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of GPIO pins, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops, legal range 2..3.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port dbus, data_bus.slave, -, register access bus using req, we, addr, wdata, gnt, rvalid and rdata.
REQ-006 SHALL have port dout, output, WIDTH, pin output values (ODR).
REQ-007 SHALL have port oe, output, WIDTH, per-pin output enable (DIR); 1 = output.
REQ-008 SHALL have port din, input, WIDTH, asynchronous pin inputs.
REQ-009 SHALL have port irq, output, 1, level interrupt equal to the OR of the ISR bits.

Function
REQ-010 SHALL decode the register offset from dbus.addr[11:0] with this map: ODR 0x000 RW; IDR 0x004 RO; DIR 0x008 RW; SET 0x00C WO, write-1-sets ODR; CLR 0x010 WO, write-1-clears ODR; IRE 0x014 RW, rising-edge enable; IFE 0x018 RW, falling-edge enable; ISR 0x01C, read, write-1-to-clear.
REQ-011 SHALL drive dbus.gnt = dbus.req combinationally, with zero wait states.
REQ-012 SHALL assert dbus.rvalid for exactly one cycle on the edge after each granted request, whether read or write.
REQ-013 SHALL register dbus.rdata on the grant edge; rdata holds its value when no read occurs.
REQ-014 SHALL zero-extend read data to 32 bits; bits [31:WIDTH] always read 0.
REQ-015 SHALL return 0 when SET, CLR or an unmapped offset is read.
REQ-016 SHALL ignore writes to IDR and to unmapped offsets.
REQ-017 SHALL use only wdata[WIDTH-1:0] on writes.
REQ-018 SHALL take register writes effect on the grant edge; dout and oe change on that same edge.
REQ-019 SHALL apply SET/CLR as ODR_nxt = ODR | wdata and ODR_nxt = ODR & ~wdata respectively.
REQ-020 SHALL pass din through a SYNC_STAGES-deep flop chain (sync); IDR = sync output, read-only.
REQ-021 SHALL update IDR at the SYNC_STAGES-th rising edge after a din change that is stable across the first edge.
REQ-022 SHALL hold prev, one register of the previous sync output, for edge detection.
REQ-023 SHALL define a rise event as sync & ~prev and a fall event as ~sync & prev.
REQ-024 SHALL set ISR bit i on the edge after an enabled rise or fall event on pin i.
REQ-025 SHALL detect edges regardless of the DIR setting.
REQ-026 SHALL clear ISR bits on an ISR write-1; for simultaneous set and W1C of the same bit, set wins.
REQ-027 SHALL NOT retroactively set ISR when IRE or IFE is changed.
REQ-028 SHALL ensure the read data for an IDR or ISR read is the value before any same-edge update.
REQ-029 SHALL drive irq registered-equivalent, i.e. combinational OR of ISR flops only.

Reset
REQ-030 SHALL, while rst = 1, force ODR, DIR, IRE, IFE, ISR, sync chain, prev, rdata and rvalid to 0, giving dout = 0, oe = 0 and irq = 0.
REQ-031 SHALL discard any request in flight when rst asserts mid-access: no rvalid and no register update.

Configuration
REQ-032 SHALL compile in the interrupt logic when macro GPIO_PORT_IRQ_EN is defined: edge detection, IRE, IFE, ISR and irq as in REQ-022..REQ-029.
REQ-033 SHALL, when GPIO_PORT_IRQ_EN is undefined, omit prev, IRE, IFE and ISR: offsets 0x014..0x01C read 0, writes are ignored, irq is tied 0, and the remaining behaviour is unchanged.

Verification
REQ-034 SHALL cover this scenario: write ODR=0x0000_00F0, then SET=0x0F, then CLR=0x30 -> dout 0xF0, 0xFF, 0xCF on successive grant edges, with rvalid pulsing once per access.
REQ-035 SHALL cover this scenario: WIDTH=8, write ODR=0xFFFF_FFFF then read ODR -> rdata 0x0000_00FF; read 0x040 -> rdata 0.
REQ-036 SHALL cover this scenario: SYNC_STAGES=2, din 0x00->0x05 before edge E0 -> IDR reads 0x05 from edge E0+1, not earlier.
REQ-037 SHALL cover this scenario: IRE=0x1, IFE=0x2, toggle din[0] and din[1] up then down -> ISR=0x1 after the din[0] rise, ISR=0x3 after the din[1] fall, irq=1; no bit set for the din[0] fall or the din[1] rise.
REQ-038 SHALL cover this scenario: an ISR=0x1 W1C write on the same edge as a new pin-0 rise event -> ISR[0] stays 1 and irq stays 1; an ISR W1C with no event -> ISR 0 and irq 0 on the next cycle.
REQ-039 SHALL cover this scenario: assert rst mid-write to DIR=0xFF -> oe=0, rvalid=0 and all registers 0 after release; without GPIO_PORT_IRQ_EN, ISR reads 0 and irq=0 under any din activity.
